// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares the CPU's single memory port between the instruction-fetch
//   requester and the load/store requester. At most one access is in flight:
//   a request seen in IDLE is latched, granted with a one-cycle pulse, driven
//   onto the memory port for MEM_LAT cycles, and completed with a one-cycle
//   valid pulse to the winning requester.
//
// Parameters:
//   AW       address width
//   DW       data width
//   MEM_LAT  memory read/write latency in cycles (1..15)
//
// Ports:
//   iClk, iRst                    clock (rising edge), async active-high reset
//   iIfReq, iIfAddr               fetch request and address
//   oIfGnt, oIfValid, oIfData     fetch grant pulse, valid pulse, fetched word
//   iDReq, iDWe, iDAddr, iDWData  load/store request, store enable, addr, data
//   oDGnt, oDValid, oDRData       data grant pulse, valid/ack pulse, load data
//   oMemAddr, oMemData            memory address / write data
//   iMemData                      memory read data
//   oMemRead, oMemWrite           memory strobes
//
// Configuration:
//   MEM_ARB_RR_EN  when defined, simultaneous requests go to the port that was
//                  not granted last. When undefined, the data port always wins
//                  a collision.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iIfReq,
    input  logic [AW-1:0] iIfAddr,
    output logic          oIfGnt,
    output logic          oIfValid,
    output logic [DW-1:0] oIfData,
    input  logic          iDReq,
    input  logic          iDWe,
    input  logic [AW-1:0] iDAddr,
    input  logic [DW-1:0] iDWData,
    output logic          oDGnt,
    output logic          oDValid,
    output logic [DW-1:0] oDRData,
    output logic [AW-1:0] oMemAddr,
    output logic [DW-1:0] oMemData,
    input  logic [DW-1:0] iMemData,
    output logic          oMemRead,
    output logic          oMemWrite
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Last value of the latency counter; the access ends when the counter
    // reaches it.
    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;
    logic          win_data_q;
    logic          win_data_d;
    logic          we_q;
    logic          we_d;
    logic          latch;
    logic          capture;
    logic          pick_data;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_data_q;
    logic [DW-1:0] if_data_q;
    logic [DW-1:0] d_rdata_q;

`ifdef MEM_ARB_RR_EN
    // Set when the data port received the most recent grant; reset state
    // means "fetch granted last", so the first collision goes to data.
    logic          last_data_q;

    // A lone request always wins; on a collision the port not granted last wins.
    always_comb begin
        pick_data = iDReq && (!iIfReq || !last_data_q);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            last_data_q <= 1'b0;
        end else if (latch) begin
            last_data_q <= pick_data;
        end
    end
`else
    // Fixed priority: the data port wins whenever it is requesting.
    always_comb begin
        pick_data = iDReq;
    end
`endif

    // State, counter and latched-access registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            win_data_q <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_data_q <= win_data_d;
            we_q       <= we_d;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE, so a requester
    // that keeps its request high past the grant cannot start a second access.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_data_d = win_data_q;
        we_d       = we_q;
        latch      = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iDReq || iIfReq) begin
                    latch      = 1'b1;
                    win_data_d = pick_data;
                    we_d       = pick_data && iDWe;
                    cnt_d      = 4'd0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    capture = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Memory-port address/data are latched at acceptance and then simply
    // held, so they keep their last value outside ACCESS. A fetch leaves the
    // write-data register untouched.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else if (latch) begin
            mem_addr_q <= pick_data ? iDAddr : iIfAddr;
            if (pick_data) begin
                mem_data_q <= iDWData;
            end
        end
    end

    // Read data lands in the winner's register on the last ACCESS cycle.
    // Stores only acknowledge, so the load-data register keeps its value.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else if (capture) begin
            if (!win_data_q) begin
                if_data_q <= iMemData;
            end else if (!we_q) begin
                d_rdata_q <= iMemData;
            end
        end
    end

    // Pulses and strobes are decoded from registered state only, so an async
    // reset drops all of them in the same instant.
    always_comb begin
        oIfGnt    = (state_q == ACCESS) && (cnt_q == 4'd0) && !win_data_q;
        oDGnt     = (state_q == ACCESS) && (cnt_q == 4'd0) &&  win_data_q;
        oMemRead  = (state_q == ACCESS) && !we_q;
        oMemWrite = (state_q == ACCESS) &&  we_q;
        oIfValid  = (state_q == RESP) && !win_data_q;
        oDValid   = (state_q == RESP) &&  win_data_q;
        oMemAddr  = mem_addr_q;
        oMemData  = mem_data_q;
        oIfData   = if_data_q;
        oDRData   = d_rdata_q;
    end

endmodule
